// File: rtl/move_command_transmitter_pkg.sv
// Shared IR protocol definitions for the move command link: timing defaults,
// command layout and FSM state encodings (also used by the rover-side receiver).
package move_command_transmitter_pkg;

   localparam int unsigned CMD_W    = 12;
   localparam int unsigned LAST_BIT = CMD_W - 1;

   // Default timing at 27 MHz: 40 kHz carrier, 0.6 ms unit, 45 ms frame
   localparam int unsigned CARRIER_DIV_DEF = 675;
   localparam int unsigned UNIT_CYCLES_DEF = 16200;
   localparam int unsigned START_UNITS_DEF = 4;
   localparam int unsigned FRAME_UNITS_DEF = 75;
   localparam int unsigned REPEATS_DEF     = 3;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_GAP   = 3'd2;
   localparam logic [2:0] ST_BIT   = 3'd3;
   localparam logic [2:0] ST_WAIT  = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   typedef struct packed {
      logic [4:0] angle;
      logic [6:0] distance;
   } move_cmd_t;

   // States during which the IR envelope is on
   function automatic logic is_burst(input logic [2:0] st);
      return (st == ST_START) || (st == ST_BIT);
   endfunction

endpackage

// File: rtl/move_command_transmitter_carrier_gen.sv
// ir_carrier_gen: square-wave IR carrier, high for the first CARRIER_DIV/2 clocks
// of each period.
// Ports: clock, reset (sync, active-high), restart (zero the phase so the next
// cycle starts a high half), carrier (carrier level for the current cycle).
module ir_carrier_gen #(
   parameter int unsigned CARRIER_DIV = 675
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   output logic carrier
);

   localparam int unsigned CNT_W = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CARRIER_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CARRIER_DIV / 2);

   logic [CNT_W-1:0] count;

   // Phase counter, wraps at CARRIER_DIV-1
   always_ff @(posedge clock) begin
      if (reset || restart) begin
         count <= '0;
      end else if (count == CNT_LAST) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   assign carrier = (count < CNT_HALF);

endmodule

// File: rtl/move_command_transmitter.sv
// move_command_transmitter: sends a 12-bit move command as REPEATS SIRC-style IR
// frames (start burst, then per bit LSB first: 1-unit gap + 1/2-unit burst).
// Ports: clock, reset (sync, active-high), send/command (request + payload,
// accepted in IDLE), busy/done (handshake), bit_index/state (debug),
// ir_out (registered carrier AND envelope).
module move_command_transmitter
   import move_command_transmitter_pkg::*;
#(
   parameter int unsigned CARRIER_DIV = CARRIER_DIV_DEF,
   parameter int unsigned UNIT_CYCLES = UNIT_CYCLES_DEF,
   parameter int unsigned START_UNITS = START_UNITS_DEF,
   parameter int unsigned FRAME_UNITS = FRAME_UNITS_DEF,
   parameter int unsigned REPEATS     = REPEATS_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             send,
   input  logic [CMD_W-1:0] command,
   output logic             busy,
   output logic             done,
   output logic [3:0]       bit_index,
   output logic [2:0]       state,
   output logic             ir_out
);

   localparam int unsigned TICK_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int unsigned REP_W  = (REPEATS > 1) ? $clog2(REPEATS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(UNIT_CYCLES - 1);
   localparam logic [6:0]        START_LAST = 7'(START_UNITS - 1);
   localparam logic [6:0]        FRAME_LAST = 7'(FRAME_UNITS - 1);
   localparam logic [REP_W-1:0]  REP_LAST   = REP_W'(REPEATS - 1);

   logic [2:0]        state_next;
   logic [TICK_W-1:0] tick, tick_next;
   logic [6:0]        unit_cnt, unit_next;
   logic [3:0]        bit_next;
   logic              second, second_next;
   logic [REP_W-1:0]  frame_cnt, frame_next;
   move_cmd_t         cmd_q;
   logic [CMD_W-1:0]  cmd_bits_c;
   logic              envelope;
   logic              env_next_c;
   logic              restart_c;
   logic              carrier_c;
   logic              unit_end_c;
   logic              frame_end_c;

   assign cmd_bits_c = cmd_q;

   ir_carrier_gen #(.CARRIER_DIV(CARRIER_DIV)) u_carrier (
      .clock   (clock),
      .reset   (reset),
      .restart (restart_c),
      .carrier (carrier_c)
   );

   // Next-state logic; every transition other than acceptance lands on a unit boundary
   always_comb begin
      state_next  = state;
      unit_next   = unit_cnt;
      bit_next    = bit_index;
      second_next = second;
      frame_next  = frame_cnt;
      frame_end_c = 1'b0;
      unit_end_c  = (tick == TICK_LAST);

      if (unit_end_c && (state != ST_IDLE) && (state != ST_DONE)) begin
         unit_next = unit_cnt + 7'd1;
      end

      case (state)
         ST_IDLE: begin
            if (send) begin
               state_next = ST_START;
               unit_next  = '0;
               frame_next = '0;
               bit_next   = '0;
            end
         end
         ST_START: begin
            if (unit_end_c && (unit_cnt == START_LAST)) begin
               state_next = ST_GAP;
            end
         end
         ST_GAP: begin
            if (unit_end_c) begin
               state_next  = ST_BIT;
               second_next = 1'b0;
            end
         end
         ST_BIT: begin
            if (unit_end_c) begin
               if (cmd_bits_c[bit_index] && !second) begin
                  second_next = 1'b1;
               end else if (bit_index == 4'(LAST_BIT)) begin
                  // A full-length frame has no room left for FRAME_WAIT
                  if (unit_cnt == FRAME_LAST) begin
                     frame_end_c = 1'b1;
                  end else begin
                     state_next = ST_WAIT;
                  end
               end else begin
                  bit_next   = bit_index + 4'd1;
                  state_next = ST_GAP;
               end
            end
         end
         ST_WAIT: begin
            if (unit_end_c && (unit_cnt == FRAME_LAST)) begin
               frame_end_c = 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (frame_end_c) begin
         unit_next = '0;
         bit_next  = '0;
         if (frame_cnt == REP_LAST) begin
            state_next = ST_DONE;
         end else begin
            state_next = ST_START;
            frame_next = frame_cnt + REP_W'(1);
         end
      end

      // Unit timer only runs while a frame is in progress
      if ((state == ST_IDLE) || (state_next == ST_IDLE) || (state_next == ST_DONE)) begin
         tick_next = '0;
      end else if (unit_end_c) begin
         tick_next = '0;
      end else begin
         tick_next = tick + TICK_W'(1);
      end

      env_next_c = is_burst(state_next);
      restart_c  = env_next_c && !envelope;
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         tick      <= '0;
         unit_cnt  <= '0;
         bit_index <= '0;
         second    <= 1'b0;
         frame_cnt <= '0;
         cmd_q     <= '0;
         envelope  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ir_out    <= 1'b0;
      end else begin
         state     <= state_next;
         tick      <= tick_next;
         unit_cnt  <= unit_next;
         bit_index <= bit_next;
         second    <= second_next;
         frame_cnt <= frame_next;
         if ((state == ST_IDLE) && send) begin
            cmd_q <= move_cmd_t'(command);
         end
         envelope  <= env_next_c;
         busy      <= (state_next != ST_IDLE) && (state_next != ST_DONE);
         done      <= (state_next == ST_DONE);
         ir_out    <= envelope & carrier_c;
      end
   end

endmodule

// File: tb/tb_move_command_transmitter.sv
// Bench for move_command_transmitter with short timing parameters
// (carrier 4 clocks, unit 8 clocks, 40-unit frames, 2 repeats).
module tb_move_command_transmitter;
   import move_command_transmitter_pkg::*;

   localparam int unsigned CDIV = 4;
   localparam int unsigned UC   = 8;
   localparam int unsigned SU   = 4;
   localparam int unsigned FU   = 40;
   localparam int unsigned REP  = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        send;
   logic [11:0] command;
   logic        busy;
   logic        done;
   logic [3:0]  bit_index;
   logic [2:0]  state;
   logic        ir_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected per-cycle trace of one accepted command, cycle 0 = first START_BURST cycle
   logic [2:0] es[$];
   logic       ec[$];
   logic [3:0] eb[$];

   move_command_transmitter #(
      .CARRIER_DIV (CDIV),
      .UNIT_CYCLES (UC),
      .START_UNITS (SU),
      .FRAME_UNITS (FU),
      .REPEATS     (REP)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .send      (send),
      .command   (command),
      .busy      (busy),
      .done      (done),
      .bit_index (bit_index),
      .state     (state),
      .ir_out    (ir_out)
   );

   always #5 clock = ~clock;

   task automatic push_seg(input logic [2:0] st, input int len, input logic burst, input int b);
      for (int j = 0; j < len; j++) begin
         es.push_back(st);
         ec.push_back(burst && ((j % 4) < 2));
         eb.push_back(4'(b));
      end
   endtask

   task automatic build_expected(input logic [11:0] cmd);
      es.delete();
      ec.delete();
      eb.delete();
      for (int f = 0; f < int'(REP); f++) begin
         int units = int'(SU);
         push_seg(ST_START, int'(SU * UC), 1'b1, 0);
         for (int i = 0; i < 12; i++) begin
            push_seg(ST_GAP, int'(UC), 1'b0, i);
            push_seg(ST_BIT, cmd[i] ? int'(2 * UC) : int'(UC), 1'b1, i);
            units += cmd[i] ? 3 : 2;
         end
         push_seg(ST_WAIT, (int'(FU) - units) * int'(UC), 1'b0, 11);
      end
      push_seg(ST_DONE, 1, 1'b0, 0);
   endtask

   // Request a transmission; returns at the sampling point of START_BURST cycle 0
   task automatic start_tx(input logic [11:0] cmd, input logic hold);
      @(negedge clock);
      send    = 1'b1;
      command = cmd;
      @(negedge clock);
      if (!hold) send = 1'b0;
   endtask

   // Walk the expected trace and tally deviations per output group
   task automatic trace_tx(input int pulse_at, input logic [11:0] pulse_cmd,
                           output int e_seq, output int e_hs, output int e_ir, output int first_bad);
      int last;
      logic exp_ir;
      last      = es.size() - 1;
      e_seq     = 0;
      e_hs      = 0;
      e_ir      = 0;
      first_bad = -1;
      for (int t = 0; t <= last; t++) begin
         if (t > 0) @(negedge clock);
         exp_ir = (t == 0) ? 1'b0 : ec[t-1];
         if ((state !== es[t]) || (bit_index !== eb[t])) begin
            e_seq++;
            if (first_bad < 0) first_bad = t;
         end
         if ((busy !== (t != last)) || (done !== (t == last))) begin
            e_hs++;
            if (first_bad < 0) first_bad = t;
         end
         if (ir_out !== exp_ir) begin
            e_ir++;
            if (first_bad < 0) first_bad = t;
         end
         if (t == pulse_at) begin
            send    = 1'b1;
            command = pulse_cmd;
         end else if (t == pulse_at + 1) begin
            send = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      reset   = 1'b1;
      send    = 1'b0;
      command = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_checks++;
      if ({busy, done, ir_out} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: busy/done/ir_out=%b required 000", {busy, done, ir_out});
      end
      n_checks++;
      if ({state, bit_index} !== {ST_IDLE, 4'd0}) begin
         n_fail++;
         $display("FAIL reset_state: state=%0d bit_index=%0d required 0/0", state, bit_index);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_cmd_005;
      int e_seq, e_hs, e_ir, fb;
      build_expected(12'h005);
      start_tx(12'h005, 1'b0);
      trace_tx(-10, 12'h000, e_seq, e_hs, e_ir, fb);
      n_checks++;
      if (e_seq != 0) begin n_fail++; $display("FAIL c005_sequence: %0d bad cycles (first %0d) required 0", e_seq, fb); end
      n_checks++;
      if (e_hs != 0) begin n_fail++; $display("FAIL c005_handshake: %0d bad cycles (first %0d) required 0", e_hs, fb); end
      n_checks++;
      if (e_ir != 0) begin n_fail++; $display("FAIL c005_ir_out: %0d bad cycles (first %0d) required 0", e_ir, fb); end
      @(negedge clock);
      n_checks++;
      if ({state, busy, done} !== {ST_IDLE, 2'b00}) begin
         n_fail++;
         $display("FAIL c005_after_done: state=%0d busy=%b done=%b required 0/0/0", state, busy, done);
      end
   endtask

   task automatic test_ignore_busy;
      int e_seq, e_hs, e_ir, fb;
      build_expected(12'h5A3);
      start_tx(12'h5A3, 1'b0);
      trace_tx(100, 12'h000, e_seq, e_hs, e_ir, fb);
      n_checks++;
      if (e_seq != 0) begin n_fail++; $display("FAIL ignore_sequence: %0d bad cycles (first %0d) required 0", e_seq, fb); end
      n_checks++;
      if (e_hs != 0) begin n_fail++; $display("FAIL ignore_handshake: %0d bad cycles (first %0d) required 0", e_hs, fb); end
      n_checks++;
      if (e_ir != 0) begin n_fail++; $display("FAIL ignore_ir_out: %0d bad cycles (first %0d) required 0", e_ir, fb); end
      @(negedge clock);
   endtask

   task automatic test_back_to_back;
      int e_seq, e_hs, e_ir, fb;
      build_expected(12'h005);
      start_tx(12'h005, 1'b1);
      command = 12'hFFF;
      trace_tx(-10, 12'h000, e_seq, e_hs, e_ir, fb);
      n_checks++;
      if ((e_seq + e_hs + e_ir) != 0) begin
         n_fail++;
         $display("FAIL held_first_tx: %0d bad cycles (first %0d) required 0", e_seq + e_hs + e_ir, fb);
      end
      @(negedge clock);
      n_checks++;
      if ({state, busy, done} !== {ST_IDLE, 2'b00}) begin
         n_fail++;
         $display("FAIL held_idle_gap: state=%0d busy=%b done=%b required 0/0/0", state, busy, done);
      end
      @(negedge clock);
      n_checks++;
      if ({state, busy} !== {ST_START, 1'b1}) begin
         n_fail++;
         $display("FAIL held_restart: state=%0d busy=%b required 1/1", state, busy);
      end
      send = 1'b0;
      build_expected(12'hFFF);
      trace_tx(-10, 12'h000, e_seq, e_hs, e_ir, fb);
      n_checks++;
      if (e_seq != 0) begin n_fail++; $display("FAIL cfff_sequence: %0d bad cycles (first %0d) required 0", e_seq, fb); end
      n_checks++;
      if (e_hs != 0) begin n_fail++; $display("FAIL cfff_handshake: %0d bad cycles (first %0d) required 0", e_hs, fb); end
      n_checks++;
      if (e_ir != 0) begin n_fail++; $display("FAIL cfff_ir_out: %0d bad cycles (first %0d) required 0", e_ir, fb); end
      @(negedge clock);
   endtask

   task automatic test_reset_mid;
      int e_seq, e_hs, e_ir, fb;
      start_tx(12'h801, 1'b0);
      repeat (10) @(negedge clock);
      n_checks++;
      if ({state, ir_out} !== {ST_START, 1'b1}) begin
         n_fail++;
         $display("FAIL mid_burst: state=%0d ir_out=%b required 1/1", state, ir_out);
      end
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({ir_out, busy, done, state} !== {3'b000, ST_IDLE}) begin
         n_fail++;
         $display("FAIL mid_reset: ir_out=%b busy=%b done=%b state=%0d required 0/0/0/0", ir_out, busy, done, state);
      end
      reset = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({state, busy, done} !== {ST_IDLE, 2'b00}) begin
         n_fail++;
         $display("FAIL mid_release: state=%0d busy=%b done=%b required 0/0/0", state, busy, done);
      end
      build_expected(12'h801);
      start_tx(12'h801, 1'b0);
      trace_tx(-10, 12'h000, e_seq, e_hs, e_ir, fb);
      n_checks++;
      if ((e_seq + e_hs + e_ir) != 0) begin
         n_fail++;
         $display("FAIL mid_restart_tx: %0d bad cycles (first %0d) required 0", e_seq + e_hs + e_ir, fb);
      end
   endtask

   initial begin
      test_reset();
      test_cmd_005();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
